// File: rtl/shift_sequencer.sv
// Two-requester sequencer that loads a granted word into the shift register and drives WIDTH shifts.
// Optional SHIFT_SEQ_FIXED_PRIORITY_EN: requester 0 always wins contention and no round-robin pointer exists.
module shift_sequencer #(
   parameter int unsigned WIDTH      = 6,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid0,
   input  logic             valid1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             ready0,
   output logic             ready1,
   input  logic             stall,
   output logic             srEnable,
   output logic             srShiftEnable,
   output logic [WIDTH-1:0] srDataIn,
   output logic             bitValid,
   output logic             grant,
   output logic             busy,
   output logic             frameDone
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned GAP_W = 4;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             grant_q, grant_d;
   logic             win;
   logic             offer;

`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
   logic rr_q, rr_d;
`endif

   // Arbitration winner: 1 selects requester 1; a lone valid requester always wins
   always_comb begin
      win = 1'b0;
`ifdef SHIFT_SEQ_FIXED_PRIORITY_EN
      win = ~valid0;
`else
      if (valid0 && valid1) win = rr_q;
      else                  win = ~valid0;
`endif
   end

   // Ready is only offered in IDLE, out of reset and unstalled
   assign offer = (state_q == S_IDLE) && reset && !stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         hold_q    <= '0;
         grant_q   <= 1'b0;
`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
         rr_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
         rr_q      <= rr_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      hold_d        = hold_q;
      grant_d       = grant_q;
`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
      rr_d          = rr_q;
`endif
      ready0        = offer && valid0 && !win;
      ready1        = offer && valid1 && win;
      srEnable      = 1'b0;
      srShiftEnable = 1'b0;
      bitValid      = 1'b0;
      frameDone     = 1'b0;
      srDataIn      = hold_q;
      busy          = (state_q != S_IDLE);
      grant         = grant_q;

      case (state_q)
         S_IDLE: begin
            if (ready0 || ready1) begin
               hold_d  = win ? data1 : data0;
               grant_d = win;
`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
               rr_d    = ~win;
`endif
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!stall) begin
               srEnable  = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!stall) begin
               srEnable      = 1'b1;
               srShiftEnable = 1'b1;
               bitValid      = 1'b1;
               if (bit_cnt_q == BIT_LAST) begin
                  frameDone = 1'b1;
                  gap_cnt_d = '0;
                  state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         S_GAP: begin
            // Gap is deliberately not frozen by stall
            if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
            else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer: two instances (GAP_CYCLES 0 and 2) against a frame-level model.
module tb_shift_sequencer;

   localparam int W = 6;

   logic          clk;
   logic          reset;
   logic          valid0, valid1, stall;
   logic [W-1:0]  data0, data1;

   logic [1:0]        rdy0, rdy1, sen, ssh, bv, gnt, bsy, fd;
   logic [1:0][W-1:0] sdi;
   logic [1:0][W-1:0] sr;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Frame-level model state per instance
   bit           m_active [2];
   int           m_prog   [2];
   int           m_gap    [2];
   logic [W-1:0] m_word   [2];
   bit           m_grant  [2];
   bit           m_rr     [2];

   int acc_c0[$], acc_w0[$], acc_c1[$], acc_w1[$], fd_c0[$], fd_g0[$], bits0[$];

   shift_sequencer #(.WIDTH(W), .GAP_CYCLES(0)) u_g0 (
      .clk(clk), .reset(reset), .valid0(valid0), .valid1(valid1),
      .data0(data0), .data1(data1), .ready0(rdy0[0]), .ready1(rdy1[0]),
      .stall(stall), .srEnable(sen[0]), .srShiftEnable(ssh[0]),
      .srDataIn(sdi[0]), .bitValid(bv[0]), .grant(gnt[0]), .busy(bsy[0]),
      .frameDone(fd[0])
   );

   shift_sequencer #(.WIDTH(W), .GAP_CYCLES(2)) u_g2 (
      .clk(clk), .reset(reset), .valid0(valid0), .valid1(valid1),
      .data0(data0), .data1(data1), .ready0(rdy0[1]), .ready1(rdy1[1]),
      .stall(stall), .srEnable(sen[1]), .srShiftEnable(ssh[1]),
      .srDataIn(sdi[1]), .bitValid(bv[1]), .grant(gnt[1]), .busy(bsy[1]),
      .frameDone(fd[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream shift register driven by each DUT
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (sen[i] && !ssh[i])     sr[i] <= sdi[i];
         else if (sen[i] && ssh[i]) sr[i] <= {sr[i][W-2:0], 1'b0};
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit v0, input bit v1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input bit st, input bit rs);
      @(negedge clk);
      valid0 = v0; valid1 = v1; data0 = d0; data1 = d1; stall = st; reset = rs;
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit           idle, w, e_r0, e_r1, shifting;
         logic [W-1:0] wv;
         int           gp;
         gp = 2 * i;
         if (!rs) begin
            m_active[i] = 0; m_prog[i] = 0; m_gap[i] = 0;
            m_word[i] = '0; m_grant[i] = 0; m_rr[i] = 0;
         end
         idle = !m_active[i] && (m_gap[i] == 0);
`ifdef SHIFT_SEQ_FIXED_PRIORITY_EN
         w = !v0;
`else
         w = (v0 && v1) ? m_rr[i] : !v0;
`endif
         e_r0 = rs && idle && !st && v0 && !w;
         e_r1 = rs && idle && !st && v1 && w;
         shifting = m_active[i] && (m_prog[i] >= 1) && !st;

         check_eq($sformatf("ready0[%0d]", i), 32'(rdy0[i]), 32'(e_r0));
         check_eq($sformatf("ready1[%0d]", i), 32'(rdy1[i]), 32'(e_r1));
         check_eq($sformatf("srEnable[%0d]", i), 32'(sen[i]), 32'(m_active[i] && !st));
         check_eq($sformatf("srShiftEnable[%0d]", i), 32'(ssh[i]), 32'(shifting));
         check_eq($sformatf("bitValid[%0d]", i), 32'(bv[i]), 32'(shifting));
         check_eq($sformatf("frameDone[%0d]", i), 32'(fd[i]), 32'(shifting && m_prog[i] == W));
         check_eq($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(!idle));
         check_eq($sformatf("grant[%0d]", i), 32'(gnt[i]), 32'(m_grant[i]));
         check_eq($sformatf("srDataIn[%0d]", i), 32'(sdi[i]), 32'(m_word[i]));
         if (rs && m_active[i] && m_prog[i] >= 1) begin
            wv = m_word[i];
            check_eq($sformatf("dataOut[%0d]", i), 32'(sr[i][W-1]), 32'(wv[W - m_prog[i]]));
         end

         if (rs) begin
            if (idle && (e_r0 || e_r1)) begin
               m_active[i] = 1; m_prog[i] = 0;
               m_word[i] = e_r1 ? d1 : d0;
               m_grant[i] = e_r1; m_rr[i] = !e_r1;
            end else if (m_active[i] && !st) begin
               if (m_prog[i] == W) begin
                  m_active[i] = 0; m_gap[i] = gp;
               end else begin
                  m_prog[i]++;
               end
            end else if (!m_active[i] && m_gap[i] > 0) begin
               m_gap[i]--;
            end
         end
      end

      if (rdy0[0] || rdy1[0]) begin acc_c0.push_back(cyc); acc_w0.push_back(int'(rdy1[0])); end
      if (rdy0[1] || rdy1[1]) begin acc_c1.push_back(cyc); acc_w1.push_back(int'(rdy1[1])); end
      if (fd[0]) begin fd_c0.push_back(cyc); fd_g0.push_back(int'(gnt[0])); end
      if (bv[0]) bits0.push_back(int'(sr[0][W-1]));
   endtask

   task automatic clear_rec();
      acc_c0.delete(); acc_w0.delete(); acc_c1.delete(); acc_w1.delete();
      fd_c0.delete(); fd_g0.delete(); bits0.delete();
   endtask

   initial begin
      logic [W-1:0] ew;
      reset = 1'b0; valid0 = 0; valid1 = 0; stall = 0; data0 = '0; data1 = '0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Single frame of 36
      clear_rec();
      step(1, 0, W'(36), 0, 0, 1);
      for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 1);
      ew = W'(36);
      check_eq("single_accepts", 32'(acc_c0.size()), 32'd1);
      check_eq("single_bitcount", 32'(bits0.size()), 32'(W));
      for (int k = 0; k < bits0.size() && k < W; k++)
         check_eq($sformatf("single_bit%0d", k), 32'(bits0[k]), 32'(ew[W-1-k]));
      check_eq("single_done_count", 32'(fd_c0.size()), 32'd1);
      if (fd_c0.size() == 1 && acc_c0.size() == 1) begin
         check_eq("single_done_lat", 32'(fd_c0[0] - acc_c0[0]), 32'(1 + W));
         check_eq("single_done_grant", 32'(fd_g0[0]), 32'd0);
      end

      // Three stall cycles after the second shift
      clear_rec();
      step(1, 0, W'(6'h2D), 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 1);
      ew = W'(6'h2D);
      check_eq("stall_bitcount", 32'(bits0.size()), 32'(W));
      for (int k = 0; k < bits0.size() && k < W; k++)
         check_eq($sformatf("stall_bit%0d", k), 32'(bits0[k]), 32'(ew[W-1-k]));
      check_eq("stall_done_count", 32'(fd_c0.size()), 32'd1);
      if (fd_c0.size() == 1 && acc_c0.size() == 1)
         check_eq("stall_done_lat", 32'(fd_c0[0] - acc_c0[0]), 32'(1 + W + 3));

      // Continuous contention
      clear_rec();
      for (int k = 0; k < 50; k++) step(1, 1, W'(6'h3F), W'(6'h00), 0, 1);
      check_eq("cont_frames_g0", 32'(acc_c0.size() >= 5), 32'd1);
      check_eq("cont_frames_g2", 32'(acc_c1.size() >= 4), 32'd1);
      for (int k = 1; k < acc_c0.size(); k++) begin
         check_eq($sformatf("cont_period_g0_%0d", k), 32'(acc_c0[k] - acc_c0[k-1]), 32'(W + 2));
`ifdef SHIFT_SEQ_FIXED_PRIORITY_EN
         check_eq($sformatf("fixed_grant_g0_%0d", k), 32'(acc_w0[k]), 32'd0);
`else
         check_eq($sformatf("cont_alt_g0_%0d", k), 32'(acc_w0[k] != acc_w0[k-1]), 32'd1);
`endif
      end
      for (int k = 1; k < acc_c1.size(); k++) begin
         check_eq($sformatf("cont_period_g2_%0d", k), 32'(acc_c1[k] - acc_c1[k-1]), 32'(W + 4));
`ifndef SHIFT_SEQ_FIXED_PRIORITY_EN
         check_eq($sformatf("cont_alt_g2_%0d", k), 32'(acc_w1[k] != acc_w1[k-1]), 32'd1);
`endif
      end

      // Reset during the third shift, then contention after release
      step(0, 0, 0, 0, 0, 0);
      clear_rec();
      step(1, 0, W'(6'h15), 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 1, W'(6'h3F), W'(6'h01), 0, 0);
      check_eq("rst_no_done", 32'(fd_c0.size()), 32'd0);
      step(1, 1, W'(6'h3F), W'(6'h01), 0, 1);
      check_eq("rst_first_ready0_g0", 32'(rdy0[0]), 32'd1);
      check_eq("rst_first_ready0_g2", 32'(rdy0[1]), 32'd1);

      // Random traffic with stalls and occasional resets
      for (int k = 0; k < 2000; k++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              W'($urandom), W'($urandom),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 199) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
